// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants for the CPU register file and its write-enable decoder.
// Optional feature (see regfile.sv): REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

endpackage : regfile_pkg

// File: rtl/regfile_decoder1to32.sv
// decoder1to32
// Turns a write address plus enable into a one-hot write-enable vector.
// Ports:
//   addr_i  [ADDR_W-1:0]     register address
//   en_i                     global write enable (gates every output bit)
//   we_o    [2**ADDR_W-1:0]  one-hot enables; all zero when en_i is low
module decoder1to32
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   en_i,
  output logic [(1<<ADDR_W)-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[addr_i] = 1'b1;
    end
  end

endmodule : decoder1to32

// File: rtl/regfile.sv
// regfile
// 32 x 32-bit CPU register file: two combinational read ports, one
// synchronous write port, r0 hardwired to zero. Synchronous active-high reset
// clears r1..r31 and wins over a simultaneous write.
// Optional feature: define REGFILE_BYPASS_EN to forward WriteData to a read
// port addressing the register being written in the same cycle.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ReadRegister1/2 [ADDR_W-1:0]    read addresses
//   ReadData1/2     [WIDTH-1:0]     read data (combinational)
//   WriteRegister   [ADDR_W-1:0]    write address
//   WriteData       [WIDTH-1:0]     write data
//   RegWrite                        write enable
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic              RegWrite
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]  we_vec;
  logic [WIDTH-1:0] rf [NREG];
  logic             unused_we0;

  decoder1to32 #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr_i (WriteRegister),
    .en_i   (RegWrite),
    .we_o   (we_vec)
  );

  // r0 has no storage, so its enable bit is intentionally dropped.
  assign unused_we0 = we_vec[0];
  assign rf[0]      = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = we_vec[i] ? WriteData : data_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign rf[i] = data_q;
  end

  logic [WIDTH-1:0] rd1_arr;
  logic [WIDTH-1:0] rd2_arr;

  // rf[0] is constant zero, so plain indexing already covers r0.
  assign rd1_arr = rf[ReadRegister1];
  assign rd2_arr = rf[ReadRegister2];

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  logic fwd1;
  logic fwd2;

  // A write that will actually land this edge; r0 and reset edges never forward.
  assign wr_live = RegWrite && !reset && (WriteRegister != '0);
  assign fwd1    = wr_live && (ReadRegister1 == WriteRegister);
  assign fwd2    = wr_live && (ReadRegister2 == WriteRegister);

  assign ReadData1 = fwd1 ? WriteData : rd1_arr;
  assign ReadData2 = fwd2 ? WriteData : rd2_arr;
`else
  assign ReadData1 = rd1_arr;
  assign ReadData2 = rd2_arr;
`endif

endmodule : regfile

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk;
  logic        reset;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic        RegWrite;

  regfile dut (
    .clk           (clk),
    .reset         (reset),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .RegWrite      (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  // Monitor: sample read ports on the falling edge, away from the capture edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (ReadData1 !== e.e1)
          $display("FAIL %s port1: got %h expected %h", e.nm, ReadData1, e.e1);
        else
          n_pass++;
        n_checks++;
        if (ReadData2 !== e.e2)
          $display("FAIL %s port2: got %h expected %h", e.nm, ReadData2, e.e2);
        else
          n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present read addresses, queue the expected data, let the monitor sample.
  task automatic expect_rd(input logic [4:0] a1, input logic [4:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input string nm);
    exp_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    e.e1 = e1;
    e.e2 = e2;
    e.nm = nm;
    sb.push_back(e);
    step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    step();
    RegWrite      = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    step();
    step();
    reset = 1'b0;

    for (int a = 0; a < 32; a++)
      expect_rd(5'(a), 5'(31 - a), 32'h0, 32'h0, "reset_all");

    wr(5'd5, 32'hDEADBEEF);
    expect_rd(5'd5, 5'd0, 32'hDEADBEEF, 32'h0, "wr_r5");

    wr(5'd0, 32'hFFFFFFFF);
    expect_rd(5'd0, 5'd5, 32'h0, 32'hDEADBEEF, "wr_r0_discard");
    expect_rd(5'd1, 5'd31, 32'h0, 32'h0, "wr_r0_no_side");

    wr(5'd3, 32'd42);
    RegWrite      = 1'b0;
    WriteRegister = 5'd3;
    WriteData     = 32'd7;
    step();
    expect_rd(5'd3, 5'd3, 32'd42, 32'd42, "we_low_hold");

    wr(5'd31, 32'h80000001);
    wr(5'd1, 32'h00000001);
    expect_rd(5'd31, 5'd1, 32'h80000001, 32'h00000001, "boundary_r31_r1");

    wr(5'd7, 32'h11111111);
    wr(5'd7, 32'h22222222);
    expect_rd(5'd7, 5'd3, 32'h22222222, 32'd42, "b2b_last_wins");

    reset = 1'b1;
    wr(5'd10, 32'd99);
    reset = 1'b0;
    expect_rd(5'd10, 5'd5, 32'h0, 32'h0, "reset_prio");
    expect_rd(5'd31, 5'd7, 32'h0, 32'h0, "reset_mid_clear");

    wr(5'd10, 32'h55);
    expect_rd(5'd10, 5'd0, 32'h55, 32'h0, "post_reset_wr");

    RegWrite      = 1'b1;
    WriteRegister = 5'd12;
    WriteData     = 32'd123;
    expect_rd(5'd12, 5'd12, BYP ? 32'd123 : 32'd0, BYP ? 32'd123 : 32'd0,
              "same_cycle_r12");
    RegWrite = 1'b0;
    expect_rd(5'd12, 5'd12, 32'd123, 32'd123, "after_edge_r12");

    RegWrite      = 1'b1;
    WriteRegister = 5'd20;
    WriteData     = 32'hA5;
    expect_rd(5'd20, 5'd12, BYP ? 32'hA5 : 32'h0, 32'd123, "fwd_port_indep");
    RegWrite = 1'b0;
    expect_rd(5'd12, 5'd20, 32'd123, 32'hA5, "after_edge_r20");

    RegWrite      = 1'b1;
    WriteRegister = 5'd0;
    WriteData     = 32'hFFFFFFFF;
    expect_rd(5'd0, 5'd0, 32'h0, 32'h0, "no_fwd_r0");
    RegWrite = 1'b0;

    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd12;
    WriteData     = 32'hCAFE;
    expect_rd(5'd12, 5'd20, 32'd123, 32'hA5, "no_fwd_in_reset");
    reset    = 1'b0;
    RegWrite = 1'b0;
    expect_rd(5'd12, 5'd20, 32'h0, 32'h0, "reset_clears_fwd");

    stim_done = 1'b1;
  end

  initial begin
    int waited;
    wait (stim_done);
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_regfile
